// File: rtl/config_frame_loader_if.sv
// Config stream in / frame write out bundle for config_frame_loader.
// slave = loader side, master = stream source and frame-write observer.
interface config_frame_loader_if #(
  parameter int ColW            = 4,
  parameter int MaxFramesPerCol = 20
);
  logic [31:0]                s_data;
  logic                       s_valid;
  logic                       s_ready;
  logic [31:0]                FrameData;
  logic [ColW-1:0]            ColSelect;
  logic [MaxFramesPerCol-1:0] FrameStrobe;
  logic                       cfg_active;
  logic                       cfg_err;

  modport slave (
    input  s_data, s_valid,
    output s_ready, FrameData, ColSelect, FrameStrobe, cfg_active, cfg_err
  );
  modport master (
    output s_data, s_valid,
    input  s_ready, FrameData, ColSelect, FrameStrobe, cfg_active, cfg_err
  );
endinterface

// File: rtl/config_frame_loader.sv
// Turns a 32-bit config word stream into column frame writes (one-hot strobe).
// Optional per-block XOR check word: define CONFIG_LOADER_CHECKSUM_EN.
module config_frame_loader #(
  parameter int NumColumns      = 16,
  parameter int MaxFramesPerCol = 20,
  parameter int ColW            = 4
) (
  input logic                  CLK,
  input logic                  resetn,
  config_frame_loader_if.slave bus
);
  localparam logic [31:0] SyncWord = 32'hFAB0_FAB1;
  localparam logic [MaxFramesPerCol-1:0] StbOne = MaxFramesPerCol'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
`ifdef CONFIG_LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_STROBE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [31:0]           r_frame_data;
  logic [ColW-1:0]       r_col;
  logic [4:0]            r_idx;
  logic [4:0]            r_rem;
  logic                  r_active;
  logic                  r_err;

  logic                  w_ready, w_accept;
  logic [7:0]            w_col;
  logic [4:0]            w_start, w_cnt;
  logic [5:0]            w_end;
  logic                  w_bad_hdr, w_last;

  // Header fields; 6-bit sum so start+count cannot wrap past the frame limit.
  assign w_col     = bus.s_data[7:0];
  assign w_start   = bus.s_data[12:8];
  assign w_cnt     = bus.s_data[20:16];
  assign w_end     = {1'b0, w_start} + {1'b0, w_cnt};
  assign w_bad_hdr = ({1'b0, w_col} >= 9'(NumColumns)) || (w_end > 6'(MaxFramesPerCol));
  assign w_last    = (r_rem == 5'd1);

  assign w_ready  = (r_state != ST_STROBE);
  assign w_accept = bus.s_valid & w_ready;

  assign bus.s_ready     = w_ready;
  assign bus.FrameData   = r_frame_data;
  assign bus.ColSelect   = r_col;
  assign bus.FrameStrobe = (r_state == ST_STROBE) ? (StbOne << r_idx) : '0;
  assign bus.cfg_active  = r_active;
  assign bus.cfg_err     = r_err;

`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [31:0] r_xor;
  logic        w_chk_bad;
  assign w_chk_bad = (bus.s_data != r_xor);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)                                  r_xor <= '0;
    else if (r_state == ST_HEADER && w_accept)    r_xor <= '0;
    else if (r_state == ST_DATA && w_accept)      r_xor <= r_xor ^ bus.s_data;
  end
`endif

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept && bus.s_data == SyncWord) w_state_nxt = ST_HEADER;
      ST_HEADER: if (w_accept) w_state_nxt = (w_cnt == '0 || w_bad_hdr) ? ST_IDLE : ST_DATA;
      ST_DATA:   if (w_accept) w_state_nxt = ST_STROBE;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      ST_STROBE: w_state_nxt = w_last ? ST_CHECK : ST_DATA;
      ST_CHECK:  if (w_accept) w_state_nxt = w_chk_bad ? ST_IDLE : ST_HEADER;
`else
      ST_STROBE: w_state_nxt = w_last ? ST_HEADER : ST_DATA;
`endif
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_frame_data <= '0;
      r_col        <= '0;
      r_idx        <= '0;
      r_rem        <= '0;
      r_active     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept && bus.s_data == SyncWord) begin
          r_active <= 1'b1;
          r_err    <= 1'b0;
        end
        ST_HEADER: if (w_accept) begin
          if (w_cnt == '0) begin
            r_active <= 1'b0;
          end else if (w_bad_hdr) begin
            r_err    <= 1'b1;
            r_active <= 1'b0;
          end else begin
            r_col <= w_col[ColW-1:0];
            r_idx <= w_start;
            r_rem <= w_cnt;
          end
        end
        ST_DATA: if (w_accept) r_frame_data <= bus.s_data;
        ST_STROBE: begin
          r_idx <= r_idx + 5'd1;
          r_rem <= r_rem - 5'd1;
        end
`ifdef CONFIG_LOADER_CHECKSUM_EN
        ST_CHECK: if (w_accept && w_chk_bad) begin
          r_err    <= 1'b1;
          r_active <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_config_frame_loader.sv
// Randomized bench: word-level reference model predicts frame writes and flags.
// Build with CONFIG_LOADER_CHECKSUM_EN to cover the check-word variant.
module tb_config_frame_loader;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic CLK = 1'b0;
  logic resetn;
  always #5 CLK = ~CLK;

  config_frame_loader_if #(.ColW(4), .MaxFramesPerCol(20)) bus ();

  config_frame_loader #(.NumColumns(16), .MaxFramesPerCol(20), .ColW(4)) dut (
    .CLK(CLK), .resetn(resetn), .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit gaps  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: word-level protocol, one entry per expected frame write.
  int          m_st;   // 0 idle, 1 header, 2 data, 3 check word
  int          m_idx, m_rem, m_col;
  logic        m_act, m_err;
  logic [31:0] m_x;
  logic [55:0] exp_q[$];
  logic [55:0] obs_q[$];

  task automatic model_reset();
    m_st = 0; m_act = 0; m_err = 0; m_x = '0;
  endtask

  task automatic model_word(input logic [31:0] w);
    int col, st, cnt;
    logic [19:0] stb;
    case (m_st)
      0: if (w == SYNC) begin m_st = 1; m_act = 1; m_err = 0; end
      1: begin
        col = int'(w[7:0]); st = int'(w[12:8]); cnt = int'(w[20:16]);
        if (cnt == 0) begin m_st = 0; m_act = 0; end
        else if (col >= 16 || st + cnt > 20) begin m_st = 0; m_act = 0; m_err = 1; end
        else begin m_col = col; m_idx = st; m_rem = cnt; m_x = '0; m_st = 2; end
      end
      2: begin
        stb = 20'd0;
        stb[m_idx] = 1'b1;
        exp_q.push_back({4'(m_col), stb, w});
        m_x ^= w;
        m_idx++; m_rem--;
`ifdef CONFIG_LOADER_CHECKSUM_EN
        if (m_rem == 0) m_st = 3;
`else
        if (m_rem == 0) m_st = 1;
`endif
      end
      3: if (w != m_x) begin m_st = 0; m_act = 0; m_err = 1; end
         else m_st = 1;
      default: m_st = 0;
    endcase
  endtask

  // Monitor: ready/strobe exclusivity, post-strobe hold, frame write capture.
  logic [31:0] p_fd;
  logic [3:0]  p_col;
  bit          p_stb = 0;
  always @(negedge CLK) begin
    if (resetn === 1'b1) begin
      chk("rdy_vs_stb", 64'(bus.s_ready), 64'(bus.FrameStrobe == 20'd0));
      if (p_stb) begin
        chk("fd_hold", 64'(bus.FrameData), 64'(p_fd));
        chk("col_hold", 64'(bus.ColSelect), 64'(p_col));
      end
      if (bus.FrameStrobe != 20'd0) obs_q.push_back({bus.ColSelect, bus.FrameStrobe, bus.FrameData});
      p_stb = (bus.FrameStrobe != 20'd0);
      p_fd  = bus.FrameData;
      p_col = bus.ColSelect;
    end else p_stb = 0;
  end

  task automatic send(input logic [31:0] w);
    bit ok = 0;
    if (gaps) begin
      bus.s_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    bus.s_data = w;
    for (int t = 0; t < 80; t++) begin
      bus.s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.s_valid && bus.s_ready) begin ok = 1; break; end
      @(negedge CLK);
    end
    if (ok) begin
      @(posedge CLK);
      @(negedge CLK);
      bus.s_valid = 1'b0;
      model_word(w);
    end else begin
      bus.s_valid = 1'b0;
      chk("send_timeout", 64'd0, 64'd1);
    end
  endtask

  function automatic logic [31:0] hdr(input int col, input int st, input int cnt);
    logic [31:0] w = $urandom;
    w[7:0] = col[7:0]; w[12:8] = st[4:0]; w[20:16] = cnt[4:0];
    return w;
  endfunction

  task automatic send_check_ok();
`ifdef CONFIG_LOADER_CHECKSUM_EN
    if (m_st == 3) send(m_x);
`endif
  endtask

  task automatic drain(input string tag);
    int n;
    repeat (3) @(negedge CLK);
    chk({tag, "_nstb"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_stb"}, 64'(obs_q[i]), 64'(exp_q[i]));
    chk({tag, "_err"}, 64'(bus.cfg_err), 64'(m_err));
    chk({tag, "_act"}, 64'(bus.cfg_active), 64'(m_act));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic basic_block();
    send(SYNC);
    chk("sync_act", 64'(bus.cfg_active), 64'd1);
    send(hdr(3, 2, 2));
    send(32'h1111_1111);
    send(32'h2222_2222);
    send_check_ok();
    send(hdr(0, 0, 0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    resetn = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      bus.s_data = $urandom;
      chk("rst_fd", 64'(bus.FrameData), 64'd0);
      chk("rst_col", 64'(bus.ColSelect), 64'd0);
      chk("rst_stb", 64'(bus.FrameStrobe), 64'd0);
      chk("rst_act", 64'(bus.cfg_active), 64'd0);
      chk("rst_err", 64'(bus.cfg_err), 64'd0);
    end
    bus.s_valid = 1'b0;
    resetn = 1'b1;
    @(negedge CLK);
    chk("rst_rdy", 64'(bus.s_ready), 64'd1);

    // Basic load, then the same block with random valid gaps
    basic_block();
    drain("basic");
    gaps = 1;
    basic_block();
    drain("gaps");
    gaps = 0;

    // Boundaries
    send(SYNC); send(hdr(15, 18, 2)); send($urandom); send($urandom); send_check_ok();
    drain("col15");
    send(hdr(16, 0, 1));
    drain("col16");
    send(SYNC);
    chk("sync_clr_err", 64'(bus.cfg_err), 64'd0);
    send(hdr(2, 19, 2));
    drain("st19");

    // Sync word inside a block is plain data
    send(SYNC); send(hdr(7, 0, 1)); send(SYNC); send_check_ok(); send(hdr(1, 1, 0));
    drain("sync_as_data");

    // Reset asserted in the cycle a data word would be accepted
    send(SYNC); send(hdr(5, 0, 3)); send(32'hDEAD_0001);
    for (int t = 0; t < 10 && !bus.s_ready; t++) @(negedge CLK);
    bus.s_data = 32'hDEAD_0002;
    bus.s_valid = 1'b1;
    resetn = 1'b0;
    @(negedge CLK);
    bus.s_valid = 1'b0;
    resetn = 1'b1;
    model_reset();
    chk("midrst_rdy", 64'(bus.s_ready), 64'd1);
    drain("midrst");
    basic_block();
    drain("post_rst");

`ifdef CONFIG_LOADER_CHECKSUM_EN
    send(SYNC); send(hdr(1, 0, 2)); send(32'hA5A5_0000); send(32'h0000_5A5A);
    send(32'hA5A5_5A5A);
    drain("ck_good");
    send(hdr(1, 0, 2)); send(32'hA5A5_0000); send(32'h0000_5A5A);
    send(32'h0000_0000);
    drain("ck_bad");
    chk("ck_bad_err", 64'(bus.cfg_err), 64'd1);
`endif

    // Randomized sessions
    for (int s = 0; s < 40; s++) begin
      int col, st, cnt;
      gaps = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) send($urandom);
      send(SYNC);
      for (int k = 0; k < 3 && m_st == 1; k++) begin
        col = $urandom_range(0, 17);
        st  = $urandom_range(0, 19);
        cnt = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 31) : $urandom_range(1, 20 - st);
        send(hdr(col, st, cnt));
        while (m_st == 2) send($urandom);
        if (m_st == 3) send(($urandom_range(0, 3) == 0) ? 32'($urandom) : m_x);
      end
      if (m_st == 1) send(hdr($urandom_range(0, 255), $urandom_range(0, 31), 0));
      drain("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
